main: RTL and testbench
=======================

MAIN -- requirements
Module: main

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive clocks the synchronized sw must differ before it is accepted.
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 50000, giving the number of clocks each display digit stays selected.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state SHALL be in this domain.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port sw, input, 1 bit, the raw asynchronous bouncing slide switch.
REQ-006 The block SHALL have port an, output, 4 bits, the active-low one-hot digit anodes, with an[0] as the rightmost digit.
REQ-007 The block SHALL have port sseg, output, 8 bits, the active-low segment lines: sseg[0]=a through sseg[6]=g, and sseg[7]=dp.

Function
REQ-008 sw SHALL pass through a 2-flop synchronizer before any other use.
REQ-009 Debounce: a stable level SHALL take the synchronized value on the edge where that value has differed from stable for DEBOUNCE_CYCLES consecutive clocks. Any clock where the two match SHALL clear the difference counter.
REQ-010 A 16-bit event count SHALL increment by 1 on the clock after each 0->1 transition of stable. A 1->0 transition SHALL NOT change the count.
REQ-011 The event count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-012 A refresh counter SHALL run 0..REFRESH_CYCLES-1 and wrap. On each wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-013 Digit index i SHALL select count nibble [4i+3:4i] and drive an low only at bit i.
REQ-014 an and sseg SHALL be registered outputs, updated every clock from the current digit index and count, with 1-clock latency.
REQ-015 The nibble-to-sseg[7:0] map SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (hex).
REQ-016 The decimal point SHALL always be off (sseg[7]=1).
REQ-017 Exactly one an bit SHALL be low on every clock after reset.
REQ-018 A sw pulse shorter than DEBOUNCE_CYCLES clocks SHALL NOT change stable or the count.
REQ-019 Counting SHALL continue independently of display refresh. A count change SHALL appear on the next clock for the selected digit.

Reset
REQ-020 While rst_n=0, all of the following SHALL hold: synchronizer flops=0, stable=0, difference counter=0, count=16'h0000, refresh counter=0, digit index=0, an=4'b1110, sseg=8'hC0.
REQ-021 Reset SHALL take effect asynchronously. Release SHALL be sampled on clk; the first digit advance SHALL occur REFRESH_CYCLES clocks after release.
REQ-022 If sw is held high through reset release, the stable 0->1 transition after debounce SHALL count once.

Structure
REQ-023 A shared package main_pkg SHALL hold the 16-entry segment table constants and the default parameter values.
REQ-024 The debounce logic SHALL be one sub-module, sw_debounce (ports clk, rst_n, sw_in, sw_stable, parameter CYCLES). The counter, multiplexer and decoder SHALL stay in main.

Verification (bench parameters DEBOUNCE_CYCLES=4, REFRESH_CYCLES=4)
REQ-025 Reset check: hold rst_n=0, then release -> an=1110 and sseg=C0; an steps through 1101, 1011, 0111, 1110 every 4 clocks, with sseg=C0 for every digit.
REQ-026 Single press: hold sw=1 for 20 clocks -> count=0001, so the digit-0 slot shows F9 and the others show C0. Releasing sw adds no count.
REQ-027 Bounce rejection: toggle sw every 2 clocks for 40 clocks, then set sw=0 -> count stays 0000.
REQ-028 Ten clean presses, each 10 clocks high and 10 low -> digit 0 shows 88 ("A") and digit 1 shows C0.
REQ-029 Wrap: force count to FFFF through 65535 presses (or a bench-only preload), then one press -> all digits show C0.
REQ-030 Mid-operation reset: assert rst_n=0 while sw=1 and count=0003 -> outputs immediately become an=1110, sseg=C0, and count=0000. After release with sw still 1, the count becomes 0001.

Source files
------------

// File: rtl/main_pkg.sv
// main_pkg: shared constants for the switch event counter display.
//   DEFAULT_DEBOUNCE_CYCLES - default debounce window, in clocks
//   DEFAULT_REFRESH_CYCLES  - default dwell time per display digit, in clocks
//   SEG_TABLE               - active-low segment patterns {dp,g,f,e,d,c,b,a},
//                             indexed by hex nibble
//   seg_decode()            - nibble to segment pattern lookup
package main_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEFAULT_REFRESH_CYCLES  = 50000;

    // Entry 0 sits in the least significant byte; dp (bit 7) is always off.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/main_sw_debounce.sv
// sw_debounce: two-flop synchronizer followed by a counting debouncer.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   sw_in     - raw asynchronous switch input
//   sw_stable - debounced level; follows the synchronized input once it has
//               differed from the current level for CYCLES consecutive clocks
module sw_debounce
    import main_pkg::*;
#(
    parameter int unsigned CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_stable
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] diff_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sw_stable <= 1'b0;
            diff_cnt  <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            if (sync2 == sw_stable) begin
                diff_cnt <= '0;
            end else if (diff_cnt == CW'(CYCLES - 1)) begin
                // This edge is the CYCLES-th consecutive differing sample.
                sw_stable <= sync2;
                diff_cnt  <= '0;
            end else begin
                diff_cnt <= diff_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/main.sv
// main: counts debounced 0->1 switch events and shows the 16-bit count in hex
// on a 4-digit multiplexed seven-segment display.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   sw    - raw bouncing slide switch
//   an    - active-low one-hot digit anodes, an[0] = rightmost digit
//   sseg  - active-low segments, sseg[0]=a .. sseg[6]=g, sseg[7]=dp
module main
    import main_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REFRESH_CYCLES  = DEFAULT_REFRESH_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic          stable;
    logic          stable_d;
    logic [15:0]   count;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit;
    logic [3:0]    nibble;

    sw_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_in    (sw),
        .sw_stable(stable)
    );

    // Count is bumped the clock after stable rises; falling edges are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            stable_d <= stable;
            if (stable && !stable_d) begin
                count <= count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit       <= '0;
        end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
            digit       <= digit + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    always_comb begin
        nibble = count[{digit, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= 4'b1110;
            sseg <= 8'hC0;
        end else begin
            an   <= ~(4'b0001 << digit);
            sseg <= seg_decode(nibble);
        end
    end

endmodule

// File: tb/tb_main.sv
// tb_main: self-checking bench for main with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=4.
module tb_main;

    localparam int DB = 4;
    localparam int RF = 4;

    localparam logic [7:0] SEG_REF [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw    = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;

    int passed = 0;
    int total  = 0;

    main #(
        .DEBOUNCE_CYCLES(DB),
        .REFRESH_CYCLES (RF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .an   (an),
        .sseg (sseg)
    );

    always #5 clk = ~clk;

    // Reference model: switch seen two clocks late, accepted after DB
    // consecutive differing samples, counted one clock after a rise; the
    // shown digit is simply (clocks since release / RF) mod 4.
    logic        m_s1, m_s2, m_stable, m_rise;
    int          m_run, m_cyc, m_d;
    logic [15:0] m_count;
    logic [3:0]  exp_an   = 4'hE;
    logic [7:0]  exp_sseg = 8'hC0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_rise = 0;
            m_run = 0; m_cyc = 0; m_count = 16'h0000;
            exp_an = 4'hE; exp_sseg = 8'hC0;
        end else begin
            m_d      = (m_cyc / RF) % 4;
            exp_an   = 4'hF ^ (4'h1 << m_d);
            exp_sseg = SEG_REF[m_count[4*m_d +: 4]];
            if (m_rise) m_count = m_count + 16'd1;
            m_rise = 0;
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DB) begin
                    m_stable = m_s2;
                    m_run    = 0;
                    if (m_stable) m_rise = 1;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = sw;
            m_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("an_model", {12'h0, an}, {12'h0, exp_an});
        chk("sseg_model", {8'h0, sseg}, {8'h0, exp_sseg});
        chk("an_onehot", 16'($countones(~an)), 16'd1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Walk one full refresh round and check each digit slot against constants.
    task automatic check_display(input string tag, input logic [3:0][7:0] e);
        int idx;
        for (int i = 0; i < 4 * RF; i++) begin
            @(negedge clk);
            check_outputs();
            case (an)
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = 0;
            endcase
            chk(tag, {8'h0, sseg}, {8'h0, e[idx]});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input int hi, input int lo);
        sw = 1'b1;
        tick(hi);
        sw = 1'b0;
        tick(lo);
    endtask

    initial begin
        // Reset state and digit scan order
        tick(3);
        chk("reset_an", {12'h0, an}, 16'h000E);
        chk("reset_sseg", {8'h0, sseg}, 16'h00C0);
        rst_n = 1'b1;
        for (int k = 0; k < 4 * RF; k++) begin
            tick(1);
            chk("scan_an", {12'h0, an}, {12'h0, ~(4'h1 << (k / RF))});
            chk("scan_sseg", {8'h0, sseg}, 16'h00C0);
        end

        // Single press, release adds nothing
        sw = 1'b1;
        tick(20);
        sw = 1'b0;
        tick(20);
        check_display("single_press", {8'hC0, 8'hC0, 8'hC0, 8'hF9});

        // Bounce shorter than the debounce window is ignored
        for (int k = 0; k < 20; k++) begin
            sw = ~sw;
            tick(2);
        end
        sw = 1'b0;
        tick(20);
        check_display("bounce", {8'hC0, 8'hC0, 8'hC0, 8'hF9});

        // Random switch activity against the model
        for (int k = 0; k < 60; k++) begin
            sw = 1'($urandom_range(0, 1));
            tick(int'($urandom_range(1, 10)));
        end
        sw = 1'b0;
        tick(20);

        // Ten clean presses from zero
        do_reset();
        for (int k = 0; k < 10; k++) press(10, 10);
        check_display("ten_presses", {8'hC0, 8'hC0, 8'hC0, 8'h88});

        // Wrap from FFFF via a preload
        tick(10);
        force dut.count = 16'hFFFF;
        m_count = 16'hFFFF;
        tick(1);
        release dut.count;
        check_display("preload", {8'h8E, 8'h8E, 8'h8E, 8'h8E});
        press(12, 12);
        check_display("wrap", {8'hC0, 8'hC0, 8'hC0, 8'hC0});

        // Mid-operation asynchronous reset with sw held high
        do_reset();
        for (int k = 0; k < 3; k++) press(10, 10);
        check_display("three_presses", {8'hC0, 8'hC0, 8'hC0, 8'hB0});
        sw = 1'b1;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {12'h0, an}, 16'h000E);
        chk("async_sseg", {8'h0, sseg}, 16'h00C0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check_display("held_through_reset", {8'hC0, 8'hC0, 8'hC0, 8'hF9});
        sw = 1'b0;
        tick(20);
        check_display("held_release", {8'hC0, 8'hC0, 8'hC0, 8'hF9});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
